axil_periph_router: RTL
=======================

AXIL_PERIPH_ROUTER -- requirements
Module: axil_periph_router

Interface
REQ-001 The module SHALL have parameter NUM_PORTS, default 2, giving the number of downstream AXI4-Lite peripheral ports (1..8).
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 64, giving the address width on all ports.
REQ-003 The module SHALL have parameter DATA_WIDTH, default 64, giving the data width on all ports (32 or 64); strobe width is DATA_WIDTH/8.
REQ-004 The module SHALL have parameter BASE_ADDR, default {64'h4010_0000, 64'h4000_0000}, a flattened NUM_PORTS*ADDR_WIDTH vector of port base addresses (port 0 in the LSBs).
REQ-005 The module SHALL have parameter ADDR_MASK, default {2{64'hFFFF_FFFF_FFF0_0000}}, a flattened NUM_PORTS*ADDR_WIDTH vector of port decode masks.
REQ-006 The module SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the downstream watchdog limit (>=2).
REQ-007 The module SHALL have port chipset_clk, input, 1 bit: the single clock.
REQ-008 The module SHALL have port chipset_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-009 The module SHALL have upstream AW signals s_awaddr/s_awvalid/s_awready: in/in/out, ADDR_WIDTH/1/1 bits.
REQ-010 The module SHALL have upstream W signals s_wdata/s_wstrb/s_wvalid/s_wready: in/in/in/out, DATA_WIDTH/DATA_WIDTH/8/1/1 bits.
REQ-011 The module SHALL have upstream B signals s_bresp/s_bvalid/s_bready: out/out/in, 2/1/1 bits.
REQ-012 The module SHALL have upstream AR signals s_araddr/s_arvalid/s_arready: in/in/out, ADDR_WIDTH/1/1 bits.
REQ-013 The module SHALL have upstream R signals s_rdata/s_rresp/s_rvalid/s_rready: out/out/out/in, DATA_WIDTH/2/1/1 bits.
REQ-014 The module SHALL have downstream signals m_awaddr, m_awvalid, m_awready, m_wdata, m_wstrb, m_wvalid, m_wready, m_bresp, m_bvalid, m_bready, m_araddr, m_arvalid, m_arready, m_rdata, m_rresp, m_rvalid and m_rready, each the upstream counterpart with opposite direction, flattened NUM_PORTS wide (port i in slice i).

Function
REQ-015 Decode SHALL select the lowest port i for which (addr & ADDR_MASK[i]) == BASE_ADDR[i]; no match is a decode miss.
REQ-016 The write FSM SHALL have states W_IDLE, W_FWD, W_RESP, W_ERR and W_BRESP, and be independent of the read FSM, with one outstanding write.
REQ-017 In W_IDLE the FSM SHALL drive s_awready=1; on AW handshake it SHALL register the address and port; it SHALL go to W_FWD on a hit or W_ERR on a miss.
REQ-018 In W_FWD the FSM SHALL hold m_awvalid[p]=1 until m_awready[p]; it SHALL pass W as m_wvalid[p]=s_wvalid&!w_done and s_wready=m_wready[p]&!w_done; it SHALL go to W_RESP when both AW and W have completed, in either order or the same cycle.
REQ-019 In W_RESP the FSM SHALL drive m_bready[p]=1; on m_bvalid[p] it SHALL capture m_bresp and go to W_BRESP.
REQ-020 In W_ERR the FSM SHALL drive s_wready=1; on s_wvalid it SHALL set bresp=2'b11 (DECERR) and go to W_BRESP.
REQ-021 In W_BRESP the FSM SHALL hold s_bvalid=1 and s_bresp stable until s_bready, then return to W_IDLE.
REQ-022 The read FSM SHALL have states R_IDLE, R_FWD, R_WAIT and R_DATA: s_arready=1 in R_IDLE, m_arvalid[p] held in R_FWD, m_rready[p]=1 in R_WAIT (capturing rdata and rresp), and s_rvalid held in R_DATA until s_rready.
REQ-023 On a read decode miss the read FSM SHALL go from R_IDLE directly to R_DATA with rdata=0 and rresp=2'b11.
REQ-024 Latency SHALL be: m_awvalid/m_arvalid asserted 1 cycle after the upstream handshake; s_bvalid/s_rvalid asserted 1 cycle after the downstream response handshake; miss response 1 cycle after the address handshake (read) or the W handshake (write).
REQ-025 Concurrent read and write to the same port SHALL proceed independently; all non-selected m_*valid and m_*ready SHALL be 0.

Reset
REQ-026 While chipset_rst=1, both FSMs SHALL be in IDLE and all valid outputs, ready outputs, s_bresp, s_rresp and s_rdata SHALL be 0, asynchronously.
REQ-027 Reset mid-transaction SHALL abandon the transaction with no response issued.

Configuration
REQ-028 With AXIL_ROUTER_TIMEOUT_EN defined, a per-FSM counter SHALL run in the FWD/RESP/WAIT states; on reaching TIMEOUT_CYCLES-1 the FSM SHALL respond 2'b10 (SLVERR, rdata=0) and set a sticky hung[p] bit; accesses to a hung port SHALL get SLVERR as for a miss; m_bready[p] and m_rready[p] SHALL be held 1 on a hung port to drain late responses.
REQ-029 Without AXIL_ROUTER_TIMEOUT_EN, no counter and no hung state SHALL exist, and the FSMs SHALL wait indefinitely.

Verification
REQ-030 Write to 0x4000_0008 with data 0xA5: m_awvalid[0] asserted the next cycle; after m_bresp=0 the bench SHALL see s_bresp=0; port 1 untouched.
REQ-031 Read 0x4010_0010 with the port returning 0x1234: s_rdata=0x1234 and s_rresp=0 one cycle after the m_rvalid handshake.
REQ-032 Read 0x5000_0000: s_rvalid the cycle after the AR handshake, with rresp=2'b11 and rdata=0; no m_arvalid asserted.
REQ-033 W presented 3 cycles before AW to port 0: the write SHALL complete correctly with a single m_wvalid beat.
REQ-034 With TIMEOUT_EN and port 1 never answering a read: SLVERR after 1024 cycles; the next read to port 1 SHALL get immediate SLVERR.
REQ-035 Assert chipset_rst while in W_RESP: all valids SHALL drop asynchronously; after release, a new write SHALL succeed.

Source files
------------

// File: rtl/axil_periph_router.sv
// AXI4-Lite 1-to-N address router with independent single-outstanding read and write FSMs.
// Optional per-FSM watchdog with sticky hung ports when AXIL_ROUTER_TIMEOUT_EN is defined.
module axil_periph_router #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] BASE_ADDR =
    {64'h0000_0000_4010_0000, 64'h0000_0000_4000_0000},
  parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] ADDR_MASK = {2{64'hFFFF_FFFF_FFF0_0000}},
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             chipset_clk,
  input  logic                             chipset_rst,
  input  logic [ADDR_WIDTH-1:0]            s_awaddr,
  input  logic                             s_awvalid,
  output logic                             s_awready,
  input  logic [DATA_WIDTH-1:0]            s_wdata,
  input  logic [DATA_WIDTH/8-1:0]          s_wstrb,
  input  logic                             s_wvalid,
  output logic                             s_wready,
  output logic [1:0]                       s_bresp,
  output logic                             s_bvalid,
  input  logic                             s_bready,
  input  logic [ADDR_WIDTH-1:0]            s_araddr,
  input  logic                             s_arvalid,
  output logic                             s_arready,
  output logic [DATA_WIDTH-1:0]            s_rdata,
  output logic [1:0]                       s_rresp,
  output logic                             s_rvalid,
  input  logic                             s_rready,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0]  m_awaddr,
  output logic [NUM_PORTS-1:0]             m_awvalid,
  input  logic [NUM_PORTS-1:0]             m_awready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  m_wdata,
  output logic [NUM_PORTS*DATA_WIDTH/8-1:0] m_wstrb,
  output logic [NUM_PORTS-1:0]             m_wvalid,
  input  logic [NUM_PORTS-1:0]             m_wready,
  input  logic [NUM_PORTS*2-1:0]           m_bresp,
  input  logic [NUM_PORTS-1:0]             m_bvalid,
  output logic [NUM_PORTS-1:0]             m_bready,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0]  m_araddr,
  output logic [NUM_PORTS-1:0]             m_arvalid,
  input  logic [NUM_PORTS-1:0]             m_arready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  m_rdata,
  input  logic [NUM_PORTS*2-1:0]           m_rresp,
  input  logic [NUM_PORTS-1:0]             m_rvalid,
  output logic [NUM_PORTS-1:0]             m_rready,
  output logic [2:0]                       dbg_wstate,
  output logic [1:0]                       dbg_rstate
);
  // All channels use AXI valid/ready: a beat transfers on a rising edge where both are 1;
  // valid never waits on ready and, once raised, holds with stable payload until accepted.
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {W_IDLE, W_FWD, W_RESP, W_ERR, W_BRESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_WAIT, R_DATA} rstate_e;

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;
  logic [PW-1:0] wport_q, wport_d, rport_q, rport_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [PW:0] aw_dec, ar_dec;
  logic aw_hung, ar_hung, aw_fin, w_fin;

  // Loop runs high to low so the lowest matching port wins; MSB of the result is the hit flag.
  function automatic logic [PW:0] decode(input logic [ADDR_WIDTH-1:0] a);
    logic [PW:0] r;
    r = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if ((a & ADDR_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH])
        r = {1'b1, PW'(i)};
    return r;
  endfunction

  assign aw_dec     = decode(s_awaddr);
  assign ar_dec     = decode(s_araddr);
  assign m_awaddr   = {NUM_PORTS{waddr_q}};
  assign m_araddr   = {NUM_PORTS{raddr_q}};
  assign m_wdata    = {NUM_PORTS{s_wdata}};
  assign m_wstrb    = {NUM_PORTS{s_wstrb}};
  assign s_bresp    = bresp_q;
  assign s_rresp    = rresp_q;
  assign s_rdata    = rdata_q;
  assign dbg_wstate = wstate_q;
  assign dbg_rstate = rstate_q;

`ifdef AXIL_ROUTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [NUM_PORTS-1:0] hung_q, hung_d;
  logic wto, rto;
  assign aw_hung = hung_q[aw_dec[PW-1:0]];
  assign ar_hung = hung_q[ar_dec[PW-1:0]];

  always_comb begin
    hung_d = hung_q;
    if (wto) hung_d[wport_q] = 1'b1;
    if (rto) hung_d[rport_q] = 1'b1;
  end
`else
  assign aw_hung = 1'b0;
  assign ar_hung = 1'b0;
`endif

  always_comb begin
    wstate_d  = wstate_q;
    wport_d   = wport_q;
    waddr_d   = waddr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bresp_d   = bresp_q;
    aw_fin    = 1'b0;
    w_fin     = 1'b0;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    m_awvalid = '0;
    m_wvalid  = '0;
    m_bready  = '0;
    case (wstate_q)
      W_IDLE: begin
        s_awready = !chipset_rst;
        if (s_awvalid && !chipset_rst) begin
          waddr_d   = s_awaddr;
          wport_d   = aw_dec[PW-1:0];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (aw_dec[PW] && !aw_hung) begin
            wstate_d = W_FWD;
          end else begin
            bresp_d  = aw_dec[PW] ? SLVERR : DECERR;
            wstate_d = W_ERR;
          end
        end
      end
      W_FWD: begin
        m_awvalid[wport_q] = !aw_done_q;
        m_wvalid[wport_q]  = s_wvalid && !w_done_q;
        s_wready           = m_wready[wport_q] && !w_done_q;
        aw_fin    = aw_done_q || m_awready[wport_q];
        w_fin     = w_done_q || (s_wvalid && m_wready[wport_q]);
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) wstate_d = W_RESP;
      end
      W_RESP: begin
        m_bready[wport_q] = 1'b1;
        if (m_bvalid[wport_q]) begin
          bresp_d  = m_bresp[wport_q*2 +: 2];
          wstate_d = W_BRESP;
        end
      end
      W_ERR: begin
        s_wready = 1'b1;
        if (s_wvalid) wstate_d = W_BRESP;
      end
      W_BRESP: begin
        s_bvalid = 1'b1;
        if (s_bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
`ifdef AXIL_ROUTER_TIMEOUT_EN
    wcnt_d = '0;
    wto    = 1'b0;
    if (wstate_q == W_FWD || wstate_q == W_RESP) begin
      wcnt_d = wcnt_q + 1'b1;
      // A response arriving on the expiry cycle still wins; otherwise abandon, absorbing any pending W.
      if (wstate_d == wstate_q && wcnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        wto      = 1'b1;
        bresp_d  = SLVERR;
        wstate_d = w_done_d ? W_BRESP : W_ERR;
      end
    end
    m_bready = m_bready | hung_q;
`endif
  end

  always_comb begin
    rstate_d  = rstate_q;
    rport_d   = rport_q;
    raddr_d   = raddr_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    m_arvalid = '0;
    m_rready  = '0;
    case (rstate_q)
      R_IDLE: begin
        s_arready = !chipset_rst;
        if (s_arvalid && !chipset_rst) begin
          raddr_d = s_araddr;
          rport_d = ar_dec[PW-1:0];
          if (ar_dec[PW] && !ar_hung) begin
            rstate_d = R_FWD;
          end else begin
            rdata_d  = '0;
            rresp_d  = ar_dec[PW] ? SLVERR : DECERR;
            rstate_d = R_DATA;
          end
        end
      end
      R_FWD: begin
        m_arvalid[rport_q] = 1'b1;
        if (m_arready[rport_q]) rstate_d = R_WAIT;
      end
      R_WAIT: begin
        m_rready[rport_q] = 1'b1;
        if (m_rvalid[rport_q]) begin
          rdata_d  = m_rdata[rport_q*DATA_WIDTH +: DATA_WIDTH];
          rresp_d  = m_rresp[rport_q*2 +: 2];
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        s_rvalid = 1'b1;
        if (s_rready) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
`ifdef AXIL_ROUTER_TIMEOUT_EN
    rcnt_d = '0;
    rto    = 1'b0;
    if (rstate_q == R_FWD || rstate_q == R_WAIT) begin
      rcnt_d = rcnt_q + 1'b1;
      if (rstate_d == rstate_q && rcnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        rto      = 1'b1;
        rdata_d  = '0;
        rresp_d  = SLVERR;
        rstate_d = R_DATA;
      end
    end
    m_rready = m_rready | hung_q;
`endif
  end

  always_ff @(posedge chipset_clk or posedge chipset_rst) begin
    if (chipset_rst) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      wport_q   <= '0;
      rport_q   <= '0;
      waddr_q   <= '0;
      raddr_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
`ifdef AXIL_ROUTER_TIMEOUT_EN
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      hung_q    <= '0;
`endif
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      wport_q   <= wport_d;
      rport_q   <= rport_d;
      waddr_q   <= waddr_d;
      raddr_q   <= raddr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
`ifdef AXIL_ROUTER_TIMEOUT_EN
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      hung_q    <= hung_d;
`endif
    end
  end
endmodule
